freq_div_ctrl: RTL and testbench

Runtime-programmable clock-divider controller. It generates a 50%-duty divided clock Clk_out from Clk_in, with a half-period of active_half input cycles, plus a one-cycle Tick_out strobe at each rising edge of Clk_out.
- The divide value is loaded through a valid/ready configuration port and applied only at period boundaries, so the output never glitches.
- Run_in starts and stops the output cleanly.
- It sits between system control logic and the peripherals that consume slow clocks or ticks.

---
 rtl/freq_div_ctrl.sv | 143 ++++++++++++++
 tb/tb_freq_div_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_div_ctrl.sv
// Runtime-programmable 50%-duty clock divider with a Tick_out strobe on every Clk_out rise.
// New half-periods arrive over a valid/ready port and only take effect at period boundaries.
module freq_div_ctrl #(
    parameter int CNT_W        = 26,
    parameter int DEFAULT_HALF = 25000000
) (
    input  logic             Clk_in,
    input  logic             Rst_in,
    input  logic             Run_in,
    input  logic [CNT_W-1:0] Cfg_half,
    input  logic             Cfg_valid,
    output logic             Cfg_ready,
    output logic             Cfg_err,
    output logic             Clk_out,
    output logic             Tick_out,
    output logic [CNT_W-1:0] Half_out,
    output logic             Pend_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             accept;
    logic             half_done;

    assign accept    = Cfg_valid & ~pend_q;
    assign half_done = (cnt_q == half_q - ONE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        err_d      = 1'b0;

        // Accepting is only possible with nothing pending, so it never races the apply below.
        if (accept) begin
            if (Cfg_half != '0) begin
                pend_d     = 1'b1;
                pend_val_d = Cfg_half;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                clk_d = 1'b0;
                cnt_d = '0;
                if (pend_q) begin
                    half_d = pend_val_q;
                    pend_d = 1'b0;
                end
                if (Run_in) begin
                    state_d = ST_HIGH;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (half_done) begin
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                    state_d = ST_LOW;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_LOW: begin
                if (half_done) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        half_d = pend_val_q;
                        pend_d = 1'b0;
                    end
                    if (Run_in) begin
                        state_d = ST_HIGH;
                        clk_d   = 1'b1;
                        tick_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk_in) begin
        if (Rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            half_q     <= HALF_RST;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    assign Cfg_ready = ~pend_q;
    assign Cfg_err   = err_q;
    assign Clk_out   = clk_q;
    assign Tick_out  = tick_q;
    assign Half_out  = half_q;
    assign Pend_out  = pend_q;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: a period-position model checked every cycle, plus directed literal checks.
module tb_freq_div_ctrl;

    localparam int CNT_W = 8;
    localparam int DEF_H = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick_out;
    logic [CNT_W-1:0] half_out;
    logic             pend_out;

    int n_checks = 0;
    int n_errors = 0;

    freq_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(DEF_H)) dut (
        .Clk_in   (clk),
        .Rst_in   (rst),
        .Run_in   (run),
        .Cfg_half (cfg_half),
        .Cfg_valid(cfg_valid),
        .Cfg_ready(cfg_ready),
        .Cfg_err  (cfg_err),
        .Clk_out  (clk_out),
        .Tick_out (tick_out),
        .Half_out (half_out),
        .Pend_out (pend_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: position within a 2*half period; high for the first half, tick at position 0.
    bit m_valid = 0;
    bit m_run   = 0;
    int m_pos   = 0;
    int m_half  = DEF_H;
    bit m_pend  = 0;
    int m_pval  = 0;
    bit m_err   = 0;

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            m_valid = 1;
            m_run   = 0;
            m_pos   = 0;
            m_half  = DEF_H;
            m_pend  = 0;
            m_err   = 0;
        end else if (m_valid) begin
            acc   = cfg_valid && !m_pend;
            m_err = acc && (cfg_half == 0);
            if (!m_run || m_pos == 2 * m_half - 1) begin
                if (m_pend) begin
                    m_half = m_pval;
                    m_pend = 0;
                end
                m_run = run;
                m_pos = 0;
            end else begin
                m_pos++;
            end
            if (acc && cfg_half != 0) begin
                m_pend = 1;
                m_pval = int'(cfg_half);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("mdl_clk_out",   32'(clk_out),   32'(m_run && m_pos < m_half));
            check("mdl_tick_out",  32'(tick_out),  32'(m_run && m_pos == 0));
            check("mdl_half_out",  32'(half_out),  32'(m_half));
            check("mdl_pend_out",  32'(pend_out),  32'(m_pend));
            check("mdl_cfg_ready", 32'(cfg_ready), 32'(!m_pend));
            check("mdl_cfg_err",   32'(cfg_err),   32'(m_err));
        end
    end

    task automatic wait_tick();
        int n = 0;
        while (tick_out !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("wait_tick_timeout", 32'(tick_out), 32'd1);
    endtask

    initial begin
        logic [12:0] exp_c;
        logic [12:0] exp_t;
        exp_c = 13'b1000111000111;
        exp_t = 13'b1000001000001;
        rst = 1'b1; run = 1'b0; cfg_half = '0; cfg_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_half",    32'(half_out), 32'd3);
        check("rst_pend",    32'(pend_out), 32'd0);
        check("rst_ready",   32'(cfg_ready), 32'd1);

        // 1: default half=3, cycles 1..13
        run = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            check("t1_clk",  32'(clk_out),  32'(exp_c[i]));
            check("t1_tick", 32'(tick_out), 32'(exp_t[i]));
        end
        check("t1_half", 32'(half_out), 32'd3);

        // 2: half=5 accepted mid-HIGH (cycle 14 -> pending at 15)
        step();
        cfg_half = 8'd5; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("t2_pend",  32'(pend_out),  32'd1);
        check("t2_ready", 32'(cfg_ready), 32'd0);
        check("t2_half_old", 32'(half_out), 32'd3);
        step(); step(); step();
        check("t2_c18_half", 32'(half_out), 32'd3);
        check("t2_c18_clk",  32'(clk_out),  32'd0);
        step();
        check("t2_c19_half", 32'(half_out), 32'd5);
        check("t2_c19_pend", 32'(pend_out), 32'd0);
        check("t2_c19_tick", 32'(tick_out), 32'd1);
        for (int i = 0; i < 5; i++) step();
        check("t2_c24_clk", 32'(clk_out), 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("t2_c29_tick", 32'(tick_out), 32'd1);

        // 3: zero configuration rejected
        cfg_half = 8'd0; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("t3_err",  32'(cfg_err),  32'd1);
        check("t3_pend", 32'(pend_out), 32'd0);
        check("t3_half", 32'(half_out), 32'd5);
        step();
        check("t3_err_clear", 32'(cfg_err), 32'd0);

        // 4: half=4, Run dropped one cycle after a rise
        cfg_half = 8'd4; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        wait_tick();
        check("t4_half", 32'(half_out), 32'd4);
        step();
        run = 1'b0;
        step(); step();
        check("t4_high_last", 32'(clk_out), 32'd1);
        step();
        check("t4_low_first", 32'(clk_out), 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("t4_idle_clk",  32'(clk_out),  32'd0);
        check("t4_idle_tick", 32'(tick_out), 32'd0);
        step(); step(); step();
        run = 1'b1;
        step();
        check("t4_restart_clk",  32'(clk_out),  32'd1);
        check("t4_restart_tick", 32'(tick_out), 32'd1);
        run = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // 5: half=1 configured in IDLE, then run
        cfg_half = 8'd1; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("t5_pend", 32'(pend_out), 32'd1);
        check("t5_half_old", 32'(half_out), 32'd4);
        run = 1'b1;
        step();
        check("t5_half", 32'(half_out), 32'd1);
        check("t5_clk0", 32'(clk_out),  32'd1);
        check("t5_tick0", 32'(tick_out), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t5_clk",  32'(clk_out),  32'(i % 2));
            check("t5_tick", 32'(tick_out), 32'(i % 2));
        end

        // 6: reset mid-LOW with a pending value
        cfg_half = 8'd6; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        wait_tick();
        check("t6_half6", 32'(half_out), 32'd6);
        step();
        cfg_half = 8'd9; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("t6_pend", 32'(pend_out), 32'd1);
        for (int i = 0; i < 5; i++) step();
        check("t6_in_low", 32'(clk_out), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_clk",   32'(clk_out),   32'd0);
        check("t6_rst_pend",  32'(pend_out),  32'd0);
        check("t6_rst_half",  32'(half_out),  32'd3);
        check("t6_rst_ready", 32'(cfg_ready), 32'd1);
        step();
        check("t6_run_clk", 32'(clk_out), 32'd1);
        for (int i = 0; i < 12; i++) step();
        check("t6_half_kept", 32'(half_out), 32'd3);

        run = 1'b0;
        for (int i = 0; i < 8; i++) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
